// File: rtl/dj_control_unit_pkg.sv
// Shared definitions for the dj control unit:
// opcodes, FSM states and instruction field positions.
package dj_control_unit_pkg;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_ALU_MAX = 8'hEF;
  localparam logic [7:0] OP_LDI     = 8'hF0;
  localparam logic [7:0] OP_BZ      = 8'hF1;
  localparam logic [7:0] OP_BN      = 8'hF2;
  localparam logic [7:0] OP_BV      = 8'hF3;
  localparam logic [7:0] OP_JMP     = 8'hF4;
  localparam logic [7:0] OP_HALT    = 8'hFF;

  localparam int OPC_LSB = 24;
  localparam int RD_LSB  = 16;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 0;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALTED
  } state_t;

  function automatic logic is_alu(input logic [7:0] op);
    return (op != OP_NOP) && (op <= OP_ALU_MAX);
  endfunction

endpackage

// File: rtl/dj_next_pc.sv
// Next program counter: taken branch/jump adds the
// sign-extended imm16, everything else steps by one.
module dj_next_pc
  import dj_control_unit_pkg::*;
#(
  parameter int PC_WIDTH = 16
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [15:0]         imm16,
  input  logic [7:0]          opcode,
  input  logic                zero,
  input  logic                negative,
  input  logic                overflow,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic                taken;
  logic [PC_WIDTH-1:0] offset;

  always_comb begin
    taken = 1'b0;
    unique case (opcode)
      OP_BZ:   taken = zero;
      OP_BN:   taken = negative;
      OP_BV:   taken = overflow;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign offset  = PC_WIDTH'($signed(imm16));
  assign next_pc = taken ? pc + offset
                         : pc + PC_WIDTH'(1);

endmodule

// File: rtl/dj_control_unit.sv
// Multi-cycle sequencer: fetch, decode, execute and
// write back over the register-file/ALU datapath.
module dj_control_unit
  import dj_control_unit_pkg::*;
#(
  parameter int PC_WIDTH   = 16,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  output logic                  instr_req,
  output logic [PC_WIDTH-1:0]   instr_addr,
  input  logic                  instr_valid,
  input  logic [31:0]           instr_data,
  output logic [ADDR_WIDTH-1:0] reg_read_addr_1,
  output logic [ADDR_WIDTH-1:0] reg_read_addr_2,
  output logic [ADDR_WIDTH-1:0] reg_write_addr,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic                  reg_write_cmd,
  output logic [7:0]            alu_operation,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  zero_flag,
  input  logic                  negative_flag,
  input  logic                  overflow_flag,
  output logic                  busy,
  output logic                  halted
);

  state_t state, state_next;

  logic [PC_WIDTH-1:0]   pc, pc_next, pc_branch, pc_inc;
  logic [31:0]           ir;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q, neg_q, ovf_q;
  logic [7:0]            opcode;
  logic [15:0]           imm16;
  logic                  pc_upd, ir_load, exe_load;

  assign opcode = ir[OPC_LSB +: 8];
  assign imm16  = ir[IMM_LSB +: 16];
  assign pc_inc = pc + PC_WIDTH'(1);

  dj_next_pc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_pc (
    .pc       (pc),
    .imm16    (imm16),
    .opcode   (opcode),
    .zero     (zero_q),
    .negative (neg_q),
    .overflow (ovf_q),
    .next_pc  (pc_branch)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    instr_req     = 1'b0;
    reg_write_cmd = 1'b0;
    alu_operation = 8'h00;
    busy          = 1'b1;
    halted        = 1'b0;
    pc_upd        = 1'b0;
    pc_next       = pc;
    ir_load       = 1'b0;
    exe_load      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_alu(opcode): state_next = S_EXECUTE;
          opcode == OP_LDI: state_next = S_WRITEBACK;
          opcode == OP_HALT: begin
            state_next = S_HALTED;
            pc_upd     = 1'b1;
            pc_next    = pc_inc;
          end
          default: begin
            state_next = S_FETCH;
            pc_upd     = 1'b1;
            pc_next    = pc_branch;
          end
        endcase
      end
      S_EXECUTE: begin
        alu_operation = opcode;
        exe_load      = 1'b1;
        state_next    = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        reg_write_cmd = 1'b1;
        pc_upd        = 1'b1;
        pc_next       = pc_inc;
        state_next    = S_FETCH;
      end
      S_HALTED: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (run) state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // flags only move on ALU execute; branches read the latched copy
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc       <= '0;
      ir       <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (pc_upd)  pc <= pc_next;
      if (ir_load) ir <= instr_data;
      if (exe_load) begin
        result_q <= alu_result;
        zero_q   <= zero_flag;
        neg_q    <= negative_flag;
        ovf_q    <= overflow_flag;
      end
    end
  end

  assign instr_addr      = pc;
  assign reg_read_addr_1 = ADDR_WIDTH'(ir[RS1_LSB +: 8]);
  assign reg_read_addr_2 = ADDR_WIDTH'(ir[RS2_LSB +: 8]);
  assign reg_write_addr  = ADDR_WIDTH'(ir[RD_LSB +: 8]);
  assign reg_write_data  = (opcode == OP_LDI) ? DATA_WIDTH'(imm16)
                                              : result_q;

endmodule
